// File: rtl/fan_curve_ctrl.sv
// Temperature-to-duty fan controller: linear fan curve with on/off hysteresis, 1 %/tick slew.
// Latency: temp_valid at N -> temp_reg at N+1 -> target and OFF exit at N+2; duty slews once per step_tick.
// No backpressure: samples are single-cycle strobes, always accepted. Optional KICK stage via `KICKSTART_EN.
module fan_curve_ctrl #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned STEP_MS  = 20,
  parameter int unsigned KICK_MS  = 500,
  parameter int unsigned T_OFF    = 32,
  parameter int unsigned T_ON     = 35,
  parameter int unsigned T_FULL   = 60,
  parameter int unsigned MIN_DUTY = 30
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] temp_data,
  input  logic       temp_valid,
  output logic [6:0] duty_data,
  output logic [1:0] fan_state
);

  localparam int unsigned TICK_CYC = CLK_FREQ / 1000 * STEP_MS;
  localparam int unsigned TICK_W   = $clog2(TICK_CYC + 1);
`ifdef KICKSTART_EN
  localparam int unsigned KICK_CYC = CLK_FREQ / 1000 * KICK_MS;
  localparam int unsigned KICK_W   = $clog2(KICK_CYC + 1);
`endif

  // Threshold ordering and duty range must hold for the curve arithmetic to be meaningful.
  localparam bit CFG_OK = (T_OFF < T_ON) && (T_ON < T_FULL) && (T_FULL <= 255) &&
                          (MIN_DUTY >= 1) && (MIN_DUTY <= 99) &&
                          (TICK_CYC >= 1) && (CLK_FREQ / 1000 * KICK_MS >= 1);

  generate
    if (!CFG_OK) begin : g_bad_cfg
      $error("fan_curve_ctrl: invalid parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
`ifdef KICKSTART_EN
    ST_KICK = 2'd1,
`endif
    ST_RUN  = 2'd2
  } state_t;

  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic              step_tick;
  logic [7:0]        temp_reg;
  logic [6:0]        target;
`ifdef KICKSTART_EN
  logic [KICK_W-1:0] kick_cnt;
`endif

  logic [7:0]  temp_ofs;
  logic [15:0] curve_prod;
  logic [6:0]  curve_add;
  logic [6:0]  target_nxt;
  logic        below_off;
  logic [6:0]  slew_goal;

  assign step_tick = (tick_cnt == TICK_W'(TICK_CYC - 1));
  assign below_off = (temp_reg < 8'(T_OFF));
  assign fan_state = state;

  // Free-running slew interval counter; step_tick marks its wrap.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt <= '0;
    end else if (step_tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Latch each temperature sample and hold it until the next strobe.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      temp_reg <= '0;
    end else if (temp_valid) begin
      temp_reg <= temp_data;
    end
  end

  // Fan curve: saturate at T_FULL, floor at MIN_DUTY, linear (truncating) in between.
  always_comb begin
    temp_ofs   = temp_reg - 8'(T_ON);
    curve_prod = {8'd0, temp_ofs} * 16'(100 - MIN_DUTY);
    curve_add  = 7'(curve_prod / 16'(T_FULL - T_ON));
    if (temp_reg >= 8'(T_FULL)) begin
      target_nxt = 7'd100;
    end else if (temp_reg < 8'(T_ON)) begin
      target_nxt = 7'(MIN_DUTY);
    end else begin
      target_nxt = 7'(MIN_DUTY) + curve_add;
    end
  end

  // Register the curve output one cycle behind temp_reg.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      target <= '0;
    end else begin
      target <= target_nxt;
    end
  end

  // Below T_OFF the fan winds down to MIN_DUTY before stopping; never aim under MIN_DUTY while running.
  always_comb begin
    slew_goal = target;
    if (below_off || (target < 7'(MIN_DUTY))) begin
      slew_goal = 7'(MIN_DUTY);
    end
  end

  // Fan state machine with registered duty command.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_OFF;
      duty_data <= '0;
`ifdef KICKSTART_EN
      kick_cnt  <= '0;
`endif
    end else begin
      case (state)
        ST_OFF: begin
          duty_data <= '0;
          if (temp_reg >= 8'(T_ON)) begin
`ifdef KICKSTART_EN
            state     <= ST_KICK;
            duty_data <= 7'd100;
            kick_cnt  <= '0;
`else
            state     <= ST_RUN;
            duty_data <= 7'(MIN_DUTY);
`endif
          end
        end
`ifdef KICKSTART_EN
        ST_KICK: begin
          duty_data <= 7'd100;
          if (kick_cnt == KICK_W'(KICK_CYC - 1)) begin
            state     <= ST_RUN;
            duty_data <= target;
            kick_cnt  <= '0;
          end else begin
            kick_cnt <= kick_cnt + 1'b1;
          end
        end
`endif
        ST_RUN: begin
          if (step_tick) begin
            if (below_off && (duty_data == 7'(MIN_DUTY))) begin
              state     <= ST_OFF;
              duty_data <= '0;
            end else if (duty_data < slew_goal) begin
              duty_data <= duty_data + 1'b1;
            end else if (duty_data > slew_goal) begin
              duty_data <= duty_data - 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_OFF;
          duty_data <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fan_curve_ctrl.sv
// Directed bench for fan_curve_ctrl: 1 ms per cycle, 2-cycle slew tick, 10-cycle kick.
// Expectations are hand-derived cycle offsets from each sample strobe (strobes start on even cycles).
// Covers both builds of the KICKSTART_EN option.
module tb_fan_curve_ctrl;

  logic       sys_clk    = 1'b0;
  logic       sys_rst_n  = 1'b0;
  logic [7:0] temp_data  = 8'd0;
  logic       temp_valid = 1'b0;
  logic [6:0] duty_data;
  logic [1:0] fan_state;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int base      = 0;
  int low_hits  = 0;

  fan_curve_ctrl #(
    .CLK_FREQ (1000),
    .STEP_MS  (2),
    .KICK_MS  (10),
    .T_OFF    (32),
    .T_ON     (35),
    .T_FULL   (60),
    .MIN_DUTY (30)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .temp_data  (temp_data),
    .temp_valid (temp_valid),
    .duty_data  (duty_data),
    .fan_state  (fan_state)
  );

  always #5 sys_clk = ~sys_clk;

  // Cycles since reset release; slew ticks land on even counts.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cyc <= 0;
    else            cyc <= cyc + 1;
  end

  // Forbidden duty values anywhere in the run.
  always @(negedge sys_clk) begin
    if (sys_rst_n && (((duty_data > 7'd0) && (duty_data < 7'd30)) || (duty_data > 7'd100)))
      low_hits = low_hits + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic apply(input logic [7:0] t);
    if (cyc % 2 != 0) cycles(1);
    base       = cyc;
    temp_data  = t;
    temp_valid = 1'b1;
    cycles(1);
    temp_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int r, input int d, input int s);
    while (cyc < base + r) cycles(1);
    chk({tag, "_duty"}, int'(duty_data), d);
    chk({tag, "_state"}, int'(fan_state), s);
  endtask

  task automatic reset_pulse(input string tag);
    sys_rst_n = 1'b0;
    #1;
    chk({tag, "_duty"}, int'(duty_data), 0);
    chk({tag, "_state"}, int'(fan_state), 0);
    cycles(2);
    sys_rst_n = 1'b1;
    cycles(20);
    chk({tag, "_idle_duty"}, int'(duty_data), 0);
    chk({tag, "_idle_state"}, int'(fan_state), 0);
  endtask

  initial begin
    cycles(3);
    chk("in_reset_duty", int'(duty_data), 0);
    chk("in_reset_state", int'(fan_state), 0);
    sys_rst_n = 1'b1;
    cycles(20);
    chk("idle_duty", int'(duty_data), 0);
    chk("idle_state", int'(fan_state), 0);

    // Start-up at 40 C: target 30 + 5*70/25 = 44.
    apply(8'd40);
`ifdef KICKSTART_EN
    expect_out("kick_entry", 2, 100, 1);
    expect_out("kick_last", 11, 100, 1);
    expect_out("kick_exit", 12, 44, 2);
    expect_out("kick_hold", 20, 44, 2);
`else
    expect_out("direct_entry", 2, 30, 2);
    expect_out("direct_step1", 4, 31, 2);
    expect_out("direct_ramp", 29, 43, 2);
    expect_out("direct_reach", 30, 44, 2);
    expect_out("direct_hold", 40, 44, 2);
`endif

    // Ramp up to 100: 56 steps, first tick still sees target 44.
    apply(8'd60);
    expect_out("up_coincide", 2, 44, 2);
    expect_out("up_step1", 4, 45, 2);
    expect_out("up_99", 113, 99, 2);
    expect_out("up_100", 114, 100, 2);
    expect_out("up_hold", 130, 100, 2);

    // 36 C -> target 32; the tick coinciding with the target update uses old target 100.
    apply(8'd36);
    expect_out("dn_coincide", 2, 100, 2);
    expect_out("dn_step1", 4, 99, 2);
    expect_out("dn_33", 137, 33, 2);
    expect_out("dn_32", 138, 32, 2);
    expect_out("dn_hold", 160, 32, 2);

    // 33 C in RUN: hysteresis band keeps the fan at MIN_DUTY.
    apply(8'd33);
    expect_out("hyst_run_old", 2, 32, 2);
    expect_out("hyst_run_31", 4, 31, 2);
    expect_out("hyst_run_30", 6, 30, 2);
    expect_out("hyst_run_hold", 40, 30, 2);

    // Back up to 44.
    apply(8'd40);
    expect_out("rerun_43", 29, 43, 2);
    expect_out("rerun_44", 30, 44, 2);

    // 31 C: wind down to 30, then off on the following tick.
    apply(8'd31);
    expect_out("shut_step1", 2, 43, 2);
    expect_out("shut_min", 28, 30, 2);
    expect_out("shut_min_hold", 29, 30, 2);
    expect_out("shut_off", 30, 0, 0);
    expect_out("shut_stay", 50, 0, 0);

    // 34 C from OFF: inside the band, stays off.
    apply(8'd34);
    expect_out("hyst_off_a", 2, 0, 0);
    expect_out("hyst_off_b", 30, 0, 0);

    // 255 C saturates the target at 100.
    apply(8'd255);
`ifdef KICKSTART_EN
    expect_out("sat_kick", 2, 100, 1);
    expect_out("sat_exit", 12, 100, 2);
    expect_out("sat_hold", 30, 100, 2);
`else
    expect_out("sat_entry", 2, 30, 2);
    expect_out("sat_step1", 4, 31, 2);
    expect_out("sat_99", 141, 99, 2);
    expect_out("sat_100", 142, 100, 2);
`endif

    reset_pulse("rst_run");

    // Reset in the middle of a kick / ramp clears outputs without waiting for an edge.
    apply(8'd40);
`ifdef KICKSTART_EN
    expect_out("pre_rst", 6, 100, 1);
`else
    expect_out("pre_rst", 6, 32, 2);
`endif
    reset_pulse("rst_mid");

    chk("no_low_duty", low_hits, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
